// File: rtl/inst_sram_bridge_pkg.sv
// Shared instruction-fetch types: address/word types, zero word and bridge FSM states.
package inst_sram_bridge_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] InstAddr_t;
  typedef logic [INST_W-1:0]      Inst_t;

  localparam Inst_t ZeroWord = '0;

  // IDLE: evaluate hit/miss, ADDR: request on bus, DATA: wait for read data
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } IfState_t;

endpackage

// File: rtl/inst_sram_bridge.sv
// Instruction fetch bridge: combinational ROM port in front of a split
// address/data SRAM-like bus, with a one-entry fetch buffer and a bypass
// path so a returning word reaches IF/ID in the same cycle it arrives.
module inst_sram_bridge
  import inst_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [ADDR_W-1:0] rom_addr_i,
  output logic [DATA_W-1:0] rom_data_o,
  output logic              stallreq_o,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_addr_ok_i,
  input  logic              inst_data_ok_i,
  input  logic [DATA_W-1:0] inst_rdata_i
);

  IfState_t          r_state;
  IfState_t          w_state_nxt;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_buf_valid;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [DATA_W-1:0] r_buf_data;

  logic              w_hit;
  logic              w_bypass;
  logic              w_launch;
  logic              w_fill;

  // Hit against the buffer entry, or bypass of the word returning right now.
  // Bypass is gated by rom_ce_i so a disabled fetch always sees a zero word.
  always_comb begin
    w_hit    = rom_ce_i & r_buf_valid & (r_buf_addr == rom_addr_i);
    w_bypass = rom_ce_i & (r_state == DATA) & inst_data_ok_i &
               (r_req_addr == rom_addr_i);
    rom_data_o = '0;
    if (w_bypass)   rom_data_o = inst_rdata_i;
    else if (w_hit) rom_data_o = r_buf_data;
    stallreq_o = rom_ce_i & ~w_hit & ~w_bypass;
  end

  // Next state and bus outputs; a new miss is only evaluated from IDLE,
  // so an outstanding transaction always runs to completion.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_fill      = 1'b0;
    inst_req_o  = 1'b0;
    inst_addr_o = r_req_addr;
    unique case (r_state)
      IDLE: begin
        if (rom_ce_i & ~w_hit) begin
          w_launch    = 1'b1;
          w_state_nxt = ADDR;
        end
      end
      ADDR: begin
        inst_req_o = 1'b1;
        if (inst_addr_ok_i) w_state_nxt = DATA;
      end
      DATA: begin
        if (inst_data_ok_i) begin
          w_fill      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, captured request address and buffer entry; reset invalidates the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req_addr  <= '0;
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch) r_req_addr <= rom_addr_i;
      if (w_fill) begin
        r_buf_valid <= 1'b1;
        r_buf_addr  <= r_req_addr;
        r_buf_data  <= inst_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_bridge.sv
// Bench for inst_sram_bridge: behavioural memory with programmable latencies,
// a transaction-level reference model, a directed vector table and random traffic.
module tb_inst_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        stallreq_o;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;

  inst_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
    .stallreq_o(stallreq_o),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i),
    .inst_rdata_i(inst_rdata_i)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Instruction memory contents
  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h3401_0020;
      32'h4:   return 32'h8C22_0004;
      32'h8:   return 32'h0043_0821;
      default: return a ^ 32'hDEAD_BEEF ^ {a[15:0], a[31:16]};
    endcase
  endfunction

  // Memory side: one transaction at a time, latencies in cycles
  int          aw_delay, dw_delay;
  bit          rnd_delays;
  bit          mb;           // address accepted, data pending
  logic [31:0] ma;
  int          ac, dc;

  // Reference model: buffer contents and the single outstanding fetch
  bit          m_valid;
  logic [31:0] m_tag, m_data;
  bit          m_pend, m_acc;
  logic [31:0] m_paddr;

  task automatic model_reset();
    m_valid = 0; m_pend = 0; m_acc = 0; m_tag = '0; m_data = '0; m_paddr = '0;
    mb = 0; ac = 0; dc = 0; ma = '0;
  endtask

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic        stall;
    logic        req;
    logic [31:0] data;
  } vec_t;

  // One clock: drive at negedge, check 1ns later, advance memory and model at posedge
  task automatic cycle(input logic ce, input logic [31:0] pc, input logic do_rst,
                       input bit use_tab, input vec_t v);
    bit          hit, byp, e_stall, e_req, req_s, aok, dok;
    logic [31:0] e_data, addr_s;
    @(negedge clk);
    rst = do_rst; rom_ce_i = ce; rom_addr_i = pc;
    aok = inst_req_o && !mb && (ac >= aw_delay);
    dok = mb && (dc >= dw_delay);
    inst_addr_ok_i = aok;
    inst_data_ok_i = dok;
    inst_rdata_i   = dok ? memf(ma) : $urandom;
    #1;
    req_s = inst_req_o; addr_s = inst_addr_o;
    if (!do_rst) begin
      hit     = ce && m_valid && (m_tag == pc);
      byp     = ce && dok && m_acc && (m_paddr == pc);
      e_stall = ce && !hit && !byp;
      e_data  = byp ? memf(pc) : hit ? m_data : 32'h0;
      e_req   = m_pend && !m_acc;
      chk("stallreq", {31'b0, stallreq_o}, {31'b0, e_stall});
      chk("rom_data", rom_data_o, e_data);
      chk("inst_req", {31'b0, inst_req_o}, {31'b0, e_req});
      if (e_req) chk("inst_addr", inst_addr_o, m_paddr);
      if (use_tab) begin
        chk("tab_stall", {31'b0, stallreq_o}, {31'b0, v.stall});
        chk("tab_req",   {31'b0, inst_req_o}, {31'b0, v.req});
        chk("tab_data",  rom_data_o, v.data);
      end
    end
    @(posedge clk);
    if (do_rst) begin
      model_reset();
    end else begin
      // memory
      if (dok) begin
        mb = 0;
        if (rnd_delays) aw_delay = $urandom_range(0, 3);
      end else if (mb) dc++;
      if (aok && req_s) begin
        mb = 1; ma = addr_s; dc = 0; ac = 0;
        if (rnd_delays) dw_delay = $urandom_range(0, 3);
      end else if (req_s) ac++;
      // model
      if (m_pend && m_acc && dok) begin
        m_valid = 1; m_tag = m_paddr; m_data = memf(m_paddr); m_pend = 0; m_acc = 0;
      end else if (m_pend && !m_acc && aok) begin
        m_acc = 1;
      end else if (!m_pend && ce && !(m_valid && m_tag == pc)) begin
        m_pend = 1; m_acc = 0; m_paddr = pc;
      end
    end
  endtask

  task automatic run(input logic ce, input logic [31:0] pc, input int n);
    vec_t z;
    z = '{ce:1'b0, pc:32'h0, stall:1'b0, req:1'b0, data:32'h0};
    for (int k = 0; k < n; k++) cycle(ce, pc, 1'b0, 1'b0, z);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  vec_t tab[12];
  vec_t z;

  initial begin
    // Sequential fills 0x0 / 0x4 / 0x8 with 1-cycle addr_ok and data_ok
    tab[0]  = '{1'b1, 32'h0, 1'b1, 1'b0, 32'h0};
    tab[1]  = '{1'b1, 32'h0, 1'b1, 1'b1, 32'h0};
    tab[2]  = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h3401_0020};
    tab[3]  = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h3401_0020};
    tab[4]  = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h3401_0020};
    tab[5]  = '{1'b1, 32'h4, 1'b1, 1'b0, 32'h0};
    tab[6]  = '{1'b1, 32'h4, 1'b1, 1'b1, 32'h0};
    tab[7]  = '{1'b1, 32'h4, 1'b0, 1'b0, 32'h8C22_0004};
    tab[8]  = '{1'b1, 32'h8, 1'b1, 1'b0, 32'h0};
    tab[9]  = '{1'b1, 32'h8, 1'b1, 1'b1, 32'h0};
    tab[10] = '{1'b1, 32'h8, 1'b0, 1'b0, 32'h0043_0821};
    tab[11] = '{1'b1, 32'h8, 1'b0, 1'b0, 32'h0043_0821};
    z = '{ce:1'b0, pc:32'h0, stall:1'b0, req:1'b0, data:32'h0};

    rst = 1; rom_ce_i = 0; rom_addr_i = '0;
    inst_addr_ok_i = 0; inst_data_ok_i = 0; inst_rdata_i = '0;
    aw_delay = 0; dw_delay = 0; rnd_delays = 0;
    model_reset();
    cycle(1'b0, 32'h0, 1'b1, 1'b0, z);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, z);

    // reset state
    @(negedge clk); rst = 0; rom_ce_i = 0; #1;
    chk("rst_req",   {31'b0, inst_req_o}, 32'h0);
    chk("rst_addr",  inst_addr_o, 32'h0);
    chk("rst_data",  rom_data_o, 32'h0);
    chk("rst_stall", {31'b0, stallreq_o}, 32'h0);

    // fill, hit, sequential fills
    for (int i = 0; i < 12; i++) cycle(tab[i].ce, tab[i].pc, 1'b0, 1'b1, tab[i]);

    // addr_ok held off 3 cycles on PC=0x4
    aw_delay = 3;
    run(1'b1, 32'h4, 7);
    chk("slow_fill_hit", rom_data_o, 32'h8C22_0004);
    aw_delay = 0;

    // rom_ce dropped while waiting for data; fill still lands and later hits
    dw_delay = 2;
    run(1'b1, 32'h20, 2);
    run(1'b0, 32'h20, 3);
    dw_delay = 0;
    run(1'b1, 32'h20, 2);
    chk("ce_drop_hit", rom_data_o, memf(32'h20));
    chk("ce_drop_noreq", {31'b0, inst_req_o}, 32'h0);

    // reset while in ADDR, buffer invalidated, PC=0x0 reissued
    aw_delay = 5;
    run(1'b1, 32'h0, 2);
    cycle(1'b1, 32'h0, 1'b1, 1'b0, z);
    aw_delay = 0;
    @(negedge clk); rst = 0; rom_ce_i = 0; #1;
    chk("midrst_req", {31'b0, inst_req_o}, 32'h0);
    run(1'b1, 32'h20, 3);  // previously buffered tag must miss now
    run(1'b1, 32'h0, 4);
    chk("reissue_hit", rom_data_o, 32'h3401_0020);

    // random traffic
    rnd_delays = 1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      pc = 32'($urandom_range(0, 5)) << 2;
      run(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, pc, 1 + $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
